uart_wrapped: RTL and testbench

- Memory-mapped UART peripheral; a slave on the D-bus next to gpio_wrapped, decoded by dbus_interconnect.
- Core writes bytes into a TX FIFO, which are serialised 8N1, LSB first, on uart_tx.
- Optional receiver deserialises uart_rx into a one-byte holding register.
- Gives firmware booting from ROM a console without polling-per-bit.

---
 rtl/uart_wrapped.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_uart_wrapped.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wrapped.sv
// uart_wrapped: memory-mapped UART slave on the D-bus.
//   TX: byte FIFO (TX_DEPTH entries) feeding an 8N1, LSB-first serialiser on uart_tx.
//   RX: optional, enabled by defining UART_RX_EN; deserialises uart_rx into a
//       one-byte holding register with VALID / overrun / framing-error flags.
// Registers (bus_addr[3:2]): 0 DATA, 1 STATUS, 2 DIV, 3 reserved (reads 0).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   bus_req/bus_we      access request (held until bus_ack) and direction
//   bus_addr/bus_wdata  byte offset and write data
//   bus_rdata/bus_ack   read data (0 outside the ack cycle) and completion pulse
//   uart_tx             serial out, idle high
//   uart_rx             serial in, asynchronous (only used with UART_RX_EN)
module uart_wrapped #(
    parameter int unsigned TX_DEPTH    = 8,
    parameter logic [15:0] DIV_DEFAULT = 16'd433
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ack,
    output logic        uart_tx,
    input  logic        uart_rx
);
    localparam int unsigned AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam logic [1:0]  REG_DATA = 2'd0;
    localparam logic [1:0]  REG_STAT = 2'd1;
    localparam logic [1:0]  REG_DIV  = 2'd2;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

    // Bus decode: an access is accepted only outside the ack cycle
    logic       acc_c;
    logic [1:0] sel_c;
    logic       push_c, data_rd_c, stat_wr_c, div_wr_c;
    assign acc_c     = bus_req && !bus_ack;
    assign sel_c     = bus_addr[3:2];
    assign push_c    = acc_c &&  bus_we && (sel_c == REG_DATA);
    assign data_rd_c = acc_c && !bus_we && (sel_c == REG_DATA);
    assign stat_wr_c = acc_c &&  bus_we && (sel_c == REG_STAT);
    assign div_wr_c  = acc_c &&  bus_we && (sel_c == REG_DIV);

    logic unused_bits;
    assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:16]};

    // TX FIFO with wrap-bit pointers
    logic [7:0]    fifo_mem [TX_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic          full_c, empty_c, pop_c, push_ok_c;
    logic [7:0]    head_c;

    assign empty_c   = (wr_ptr_q == rd_ptr_q);
    assign full_c    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign push_ok_c = push_c && (!full_c || pop_c);
    assign head_c    = fifo_mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok_c) fifo_mem[wr_ptr_q[AW-1:0]] <= bus_wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok_c) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_c)     rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // RX status view (constant zero when the receiver is not built)
    logic [7:0] rx_byte_c;
    logic       rx_valid_c, rx_ovr_c, rx_ferr_c;

    // Bus registers: ack, read data, divider, TX overflow flag
    logic [15:0] div_q;
    logic        tx_ovf_q;
    logic        tx_busy_c;
    logic [31:0] rdata_c;

    always_comb begin
        rdata_c = '0;
        case (sel_c)
            REG_DATA: rdata_c = {24'b0, rx_byte_c};
            REG_STAT: rdata_c = {25'b0, rx_ferr_c, tx_ovf_q, rx_ovr_c, rx_valid_c,
                                 tx_busy_c, empty_c, full_c};
            REG_DIV:  rdata_c = {16'b0, div_q};
            default:  rdata_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
            div_q     <= DIV_DEFAULT;
            tx_ovf_q  <= 1'b0;
        end else begin
            bus_ack   <= acc_c;
            bus_rdata <= (acc_c && !bus_we) ? rdata_c : '0;
            if (div_wr_c) div_q <= bus_wdata[15:0];
            // A push on a full FIFO is only lost if the serialiser is not popping
            if (push_c && full_c && !pop_c)     tx_ovf_q <= 1'b1;
            else if (stat_wr_c && bus_wdata[5]) tx_ovf_q <= 1'b0;
        end
    end

    // TX serialiser state
    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        tx_d;

    assign tx_busy_c = (tx_state_q != TX_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            uart_tx    <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            uart_tx    <= tx_d;
        end
    end

    // TX next state; the baud counter reloads from div_q only at bit boundaries
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_d       = uart_tx;
        pop_c      = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!empty_c) begin
                    pop_c      = 1'b1;
                    tx_sh_d    = head_c;
                    tx_cnt_d   = div_q;
                    tx_d       = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = div_q;
                    tx_bit_d   = 3'd0;
                    tx_d       = tx_sh_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d = div_q;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                        tx_d     = tx_sh_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == 16'd0) begin
                    // Back-to-back frames: chain straight into the next start bit
                    if (!empty_c) begin
                        pop_c      = 1'b1;
                        tx_sh_d    = head_c;
                        tx_cnt_d   = div_q;
                        tx_d       = 1'b0;
                        tx_state_d = TX_START;
                    end else begin
                        tx_d       = 1'b1;
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

`ifdef UART_RX_EN
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    rx_state_e   rx_state_q, rx_state_d;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [7:0]  rx_byte_q;
    logic        rx_valid_q, rx_ovr_q, rx_ferr_q;
    logic        rx_load_c, rx_ferr_set_c;
    logic [15:0] rx_half_c;

    // Half a bit period, widened so DIV=0xFFFF does not overflow
    assign rx_half_c = 16'((17'(div_q) + 17'd1) >> 1);

    // Two-flop synchroniser plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= uart_rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
        end
    end

    // RX next state: every sample is taken when the counter reaches zero
    always_comb begin
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_bit_d      = rx_bit_q;
        rx_sh_d       = rx_sh_q;
        rx_load_c     = 1'b0;
        rx_ferr_set_c = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_cnt_d   = rx_half_c;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == 16'd0) begin
                    if (rx_s2_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = div_q;
                        rx_bit_d   = 3'd0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_cnt_d = div_q;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == 16'd0) begin
                    if (rx_s2_q) rx_load_c     = 1'b1;
                    else         rx_ferr_set_c = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Holding register and flags; a load beats a concurrent DATA read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            if (rx_load_c) begin
                rx_byte_q  <= rx_sh_q;
                rx_valid_q <= 1'b1;
            end else if (data_rd_c) begin
                rx_valid_q <= 1'b0;
            end
            if (rx_load_c && rx_valid_q)        rx_ovr_q <= 1'b1;
            else if (stat_wr_c && bus_wdata[4]) rx_ovr_q <= 1'b0;
            if (rx_ferr_set_c)                  rx_ferr_q <= 1'b1;
            else if (stat_wr_c && bus_wdata[6]) rx_ferr_q <= 1'b0;
        end
    end

    assign rx_byte_c  = rx_byte_q;
    assign rx_valid_c = rx_valid_q;
    assign rx_ovr_c   = rx_ovr_q;
    assign rx_ferr_c  = rx_ferr_q;
`else
    logic unused_rx;
    assign unused_rx  = ^{uart_rx, data_rd_c, bus_wdata[6], bus_wdata[4]};
    assign rx_byte_c  = '0;
    assign rx_valid_c = 1'b0;
    assign rx_ovr_c   = 1'b0;
    assign rx_ferr_c  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_wrapped.sv
// Self-checking bench for uart_wrapped: directed sequence with random payloads,
// checked against a frame-level model of the serial line and status flags.
module tb_uart_wrapped;
    localparam int unsigned TX_DEPTH = 8;
`ifdef UART_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_req = 1'b0;
    logic        bus_we = 1'b0;
    logic [3:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        uart_tx;
    logic        uart_rx = 1'b1;

    int checks = 0;
    int errors = 0;

    logic       rec_on = 1'b0;
    logic       trace[$];
    logic [7:0] exp_bytes[$];

    // Reference RX flag model
    bit         m_valid = 1'b0;
    bit         m_ovr = 1'b0;
    bit         m_ferr = 1'b0;
    logic [7:0] m_byte = '0;

    uart_wrapped #(.TX_DEPTH(TX_DEPTH), .DIV_DEFAULT(16'd433)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .uart_tx   (uart_tx),
        .uart_rx   (uart_rx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rec_on) trace.push_back(uart_tx);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_word(input bit full, input bit empty, input bit busy,
                                                input bit ovf);
        return {25'b0, m_ferr, ovf, m_ovr, m_valid, busy, empty, full};
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus access; ack must appear exactly one cycle after the request is seen
    task automatic bus(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd);
        @(posedge clk);
        #1;
        bus_req   = 1'b1;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wd;
        @(posedge clk);
        #1;
        chk("ack_latency", 32'(bus_ack), 32'd1);
        rd        = bus_rdata;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] wd);
        logic [31:0] dummy;
        bus(1'b1, addr, wd, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        bus(1'b0, addr, 32'd0, v);
        chk(tag, v, exp);
    endtask

    task automatic start_rec();
        trace.delete();
        rec_on = 1'b1;
    endtask

    // Compare the recorded line against ideal contiguous 8N1 frames of exp_bytes
    task automatic check_trace(input string tag, input int div, output int first);
        logic ideal[$];
        int   bad = 0;
        first = -1;
        rec_on = 1'b0;
        for (int i = 0; i < trace.size(); i++) begin
            if (trace[i] == 1'b0) begin
                first = i;
                break;
            end
        end
        foreach (exp_bytes[k]) begin
            logic [7:0] b;
            b = exp_bytes[k];
            repeat (div + 1) ideal.push_back(1'b0);
            for (int j = 0; j < 8; j++) repeat (div + 1) ideal.push_back(b[j]);
            repeat (div + 1) ideal.push_back(1'b1);
        end
        repeat (4) ideal.push_back(1'b1);
        if (first < 0) begin
            bad = ideal.size();
        end else begin
            for (int i = 0; i < ideal.size(); i++) begin
                if (first + i >= trace.size() || trace[first + i] !== ideal[i]) bad++;
            end
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop_bit, input int div);
        @(posedge clk);
        #1;
        uart_rx = 1'b0;
        wait_cycles(div + 1);
        for (int j = 0; j < 8; j++) begin
            uart_rx = b[j];
            wait_cycles(div + 1);
        end
        uart_rx = stop_bit;
        wait_cycles(div + 1);
        uart_rx = 1'b1;
        wait_cycles(div + 5);
    endtask

    function automatic void model_rx(input logic [7:0] b, input bit stop_bit);
        if (!RX_EN) return;
        if (stop_bit) begin
            if (m_valid) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_byte  = b;
        end else begin
            m_ferr = 1'b1;
        end
    endfunction

    initial begin
        int         first;
        int         div;
        int         m_cnt;
        int         dropped;
        logic [7:0] b;

        // Reset state
        wait_cycles(2);
        chk("reset_tx", 32'(uart_tx), 32'd1);
        chk("reset_ack", 32'(bus_ack), 32'd0);
        chk("reset_rdata", bus_rdata, 32'd0);
        rst_n = 1'b1;
        wait_cycles(1);
        rd_chk("reset_status", 4'h4, status_word(0, 1, 0, 0));
        rd_chk("reset_div", 4'h8, 32'h1B1);
        wait_cycles(1);
        chk("idle_rdata", bus_rdata, 32'd0);
        chk("idle_ack", 32'(bus_ack), 32'd0);

        // DIV width and reserved register
        wr(4'h8, 32'hFFFF_0003);
        rd_chk("div_upper_zero", 4'h8, 32'h3);
        wr(4'hC, 32'hFFFF_FFFF);
        rd_chk("reg_c_zero", 4'hC, 32'h0);

        // Single 0x55 frame at DIV=3, with start latency and busy flag
        exp_bytes = '{8'h55};
        start_rec();
        wr(4'h0, 32'h55);
        rd_chk("busy_mid_frame", 4'h4, status_word(0, 1, 1, 0));
        wait_cycles(50);
        rd_chk("idle_after_frame", 4'h4, status_word(0, 1, 0, 0));
        check_trace("frame_55", 3, first);
        // index 3: pre-request, request, ack cycles high; line falls the cycle after ack
        chk("tx_start_latency", 32'(first), 32'd3);

        // DIV=0 burst of random bytes: one-cycle bits, frames back-to-back
        wr(4'h8, 32'd0);
        exp_bytes.delete();
        start_rec();
        for (int k = 0; k < 5; k++) begin
            b = 8'($urandom);
            exp_bytes.push_back(b);
            wr(4'h0, {24'b0, b});
        end
        wait_cycles(70);
        check_trace("burst_div0", 0, first);

        // Overflow: first byte leaves the FIFO at once, the rest fill it during frame one
        div = 2 + int'($urandom_range(2, 0));
        wr(4'h8, 32'(div));
        exp_bytes.delete();
        m_cnt   = 0;
        dropped = 0;
        start_rec();
        for (int k = 0; k < 10; k++) begin
            b = 8'($urandom);
            if (k == 0) begin
                exp_bytes.push_back(b);
            end else if (m_cnt < TX_DEPTH) begin
                exp_bytes.push_back(b);
                m_cnt++;
            end else begin
                dropped++;
            end
            wr(4'h0, {24'b0, b});
        end
        rd_chk("ovf_status", 4'h4, status_word(m_cnt == TX_DEPTH, 0, 1, dropped > 0));
        wr(4'h4, 32'h20);
        rd_chk("ovf_cleared", 4'h4, status_word(m_cnt == TX_DEPTH, 0, 1, 0));
        wait_cycles(10 * (div + 1) * exp_bytes.size() + 20);
        check_trace("ovf_frames", div, first);
        rd_chk("ovf_drained", 4'h4, status_word(0, 1, 0, 0));

        // Reset in the middle of a frame
        wr(4'h8, 32'd3);
        wr(4'h0, 32'h00);
        wr(4'h0, {24'b0, 8'($urandom)});
        wait_cycles(12);
        chk("pre_reset_low", 32'(uart_tx), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_tx", 32'(uart_tx), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_rec();
        wait_cycles(1);
        rd_chk("post_reset_status", 4'h4, status_word(0, 1, 0, 0));
        rd_chk("post_reset_div", 4'h8, 32'h1B1);
        wait_cycles(30);
        rec_on = 1'b0;
        first = 0;
        foreach (trace[i]) if (trace[i] !== 1'b1) first++;
        chk("post_reset_line_idle", 32'(first), 32'd0);

        // Receiver (constant-zero view when not built)
        wr(4'h8, 32'd7);
        b = 8'hA3;
        send_rx(b, 1'b1, 7);
        model_rx(b, 1'b1);
        rd_chk("rx_valid", 4'h4, status_word(0, 1, 0, 0));
        rd_chk("rx_data", 4'h0, {24'b0, RX_EN ? m_byte : 8'h00});
        m_valid = 1'b0;
        rd_chk("rx_valid_cleared", 4'h4, status_word(0, 1, 0, 0));
        b = 8'($urandom);
        send_rx(b, 1'b1, 7);
        model_rx(b, 1'b1);
        b = 8'($urandom);
        send_rx(b, 1'b1, 7);
        model_rx(b, 1'b1);
        rd_chk("rx_overrun", 4'h4, status_word(0, 1, 0, 0));
        rd_chk("rx_overwrite", 4'h0, {24'b0, RX_EN ? m_byte : 8'h00});
        m_valid = 1'b0;
        wr(4'h4, 32'h10);
        m_ovr = 1'b0;
        rd_chk("rx_ovr_cleared", 4'h4, status_word(0, 1, 0, 0));
        send_rx(8'($urandom), 1'b0, 7);
        model_rx(8'h00, 1'b0);
        rd_chk("rx_ferr", 4'h4, status_word(0, 1, 0, 0));
        wr(4'h4, 32'h40);
        m_ferr = 1'b0;
        @(posedge clk);
        #1;
        uart_rx = 1'b0;
        wait_cycles(2);
        uart_rx = 1'b1;
        wait_cycles(40);
        rd_chk("rx_glitch_ignored", 4'h4, status_word(0, 1, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
